// File: rtl/simd_mac_pkg.sv
// rtl/simd_mac_pkg.sv - shared constants and FSM encoding for simd_mac_collector
package simd_mac_pkg;
    localparam logic [1:0] MODE_INT8 = 2'b00;
    localparam logic [1:0] MODE_INT4 = 2'b01;
    localparam logic [1:0] MODE_INT2 = 2'b10;

    localparam int DEF_ACC_W = 24;
    localparam int DEF_LEN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/simd_mac_collector_if.sv
// rtl/simd_mac_collector_if.sv - product stream in, lane-sum result stream out
interface simd_mac_collector_if #(
    parameter int ACC_W = simd_mac_pkg::DEF_ACC_W
) ();
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      result;
    logic [7:0]       result_int4_0;
    logic [7:0]       result_int4_1;
    logic [3:0]       result_int2_0;
    logic [3:0]       result_int2_1;
    logic [3:0]       result_int2_2;
    logic [3:0]       result_int2_3;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc0;
    logic [ACC_W-1:0] acc1;
    logic [ACC_W-1:0] acc2;
    logic [ACC_W-1:0] acc3;
    logic [1:0]       out_mode;
    logic             ovf;

    modport slave (
        input  in_valid, result, result_int4_0, result_int4_1,
               result_int2_0, result_int2_1, result_int2_2, result_int2_3, out_ready,
        output in_ready, out_valid, acc0, acc1, acc2, acc3, out_mode, ovf
    );

    modport master (
        output in_valid, result, result_int4_0, result_int4_1,
               result_int2_0, result_int2_1, result_int2_2, result_int2_3, out_ready,
        input  in_ready, out_valid, acc0, acc1, acc2, acc3, out_mode, ovf
    );
endinterface

// File: rtl/simd_lane_sat_add.sv
// rtl/simd_lane_sat_add.sv - one lane: accumulator plus 16-bit unsigned addend, saturating
module simd_lane_sat_add import simd_mac_pkg::*; #(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [15:0]      addend,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);
    logic [ACC_W:0] wide;

    always_comb begin
        wide = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, addend};
        ovf  = wide[ACC_W];
        sum  = wide[ACC_W] ? '1 : wide[ACC_W-1:0];
    end
endmodule

// File: rtl/simd_mac_collector.sv
// rtl/simd_mac_collector.sv - per-lane dot-product accumulator behind the SIMD multiplier
module simd_mac_collector import simd_mac_pkg::*; #(
    parameter int ACC_W = DEF_ACC_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    simd_mac_collector_if.slave bus
);
    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] acc_q [4];
    logic [ACC_W-1:0] acc_d [4];
    logic [ACC_W-1:0] lane_sum [4];
    logic [15:0]      addend [4];
    logic [3:0]       lane_ovf;

    // Lanes not used by the latched mode get a zero addend, so they stay at 0.
    always_comb begin
        for (int i = 0; i < 4; i++) addend[i] = '0;
        case (mode_q)
            MODE_INT4: begin
                addend[0] = {8'h00, bus.result_int4_0};
                addend[1] = {8'h00, bus.result_int4_1};
            end
            MODE_INT2: begin
                addend[0] = {12'h000, bus.result_int2_0};
                addend[1] = {12'h000, bus.result_int2_1};
                addend[2] = {12'h000, bus.result_int2_2};
                addend[3] = {12'h000, bus.result_int2_3};
            end
            default: addend[0] = bus.result;
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        simd_lane_sat_add #(.ACC_W(ACC_W)) u_lane (
            .acc    (acc_q[g]),
            .addend (addend[g]),
            .sum    (lane_sum[g]),
            .ovf    (lane_ovf[g])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        for (int i = 0; i < 4; i++) acc_d[i] = acc_q[i];
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int i = 0; i < 4; i++) acc_d[i] = '0;
                    ovf_d   = 1'b0;
                    mode_d  = mode;
                    cnt_d   = len;
                    state_d = (len != '0) ? ST_ACC : ST_DONE;
                end
            end
            ST_ACC: begin
                if (bus.in_valid) begin
                    for (int i = 0; i < 4; i++) acc_d[i] = lane_sum[i];
                    ovf_d = ovf_q | (|lane_ovf);
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < 4; i++) acc_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < 4; i++) acc_q[i] <= acc_d[i];
        end
    end

    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.out_valid = (state_q == ST_DONE);
    assign busy          = (state_q != ST_IDLE);
    assign bus.acc0      = acc_q[0];
    assign bus.acc1      = acc_q[1];
    assign bus.acc2      = acc_q[2];
    assign bus.acc3      = acc_q[3];
    assign bus.out_mode  = mode_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: doc/simd_mac_collector.md
# simd_mac_collector

Sequential accumulator at the output side of the combinational `eight_bit_multiplier`. It consumes that multiplier's product buses over a valid/ready stream and sums a job of `len` products per SIMD lane (1×INT8, 2×INT4 or 4×INT2). It then presents the per-lane sums on a valid/ready result port. This turns the multiplier into a dot-product engine; upstream drives operands, this block is the receiving end.

## Interface
- `ACC_W`, 24, accumulator width per lane (≥16)
- `LEN_W`, 8, job-length counter width
- `CLK`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  job start pulse; sampled only in IDLE
- `mode`  in  2  lane mode, latched at start: 00 INT8, 01 INT4, 10 INT2, 11 reserved (treated as INT8)
- `len`  in  LEN_W  products in job, latched at start
- `in_valid`  in  1  product beat valid
- `in_ready`  out  1  product beat accepted when `in_valid && in_ready`
- `result`  in  16  INT8 product (unsigned)
- `result_int4_0`, `result_int4_1`  in  8 each  INT4 lane products
- `result_int2_0`..`result_int2_3`  in  4 each  INT2 lane products
- `out_valid`  out  1  sums valid
- `out_ready`  in  1  sink accepts sums
- `acc0`..`acc3`  out  ACC_W each  lane sums; unused lanes 0
- `out_mode`  out  2  latched mode of presented job
- `ovf`  out  1  sticky: some lane saturated during the job
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states:
  - IDLE: `start && len!=0` → ACC. `start && len==0` → DONE with all sums 0.
  - ACC: exits to DONE on the accepted beat that brings the counter to 0.
  - DONE: exits to IDLE on `out_valid && out_ready`.
- On start: clear `acc0..3` and `ovf`, latch `mode` into `out_mode`, load counter with `len`.
- Per accepted beat, all values zero-extended and unsigned:
  - INT8: `acc0 += result`.
  - INT4: `acc0 += result_int4_0`, `acc1 += result_int4_1`.
  - INT2: `accN += result_int2_N` for N=0..3.
  - Inactive lanes stay 0.
- Saturating add: if sum > 2^ACC_W−1, lane holds all-ones and `ovf` is set. `ovf` stays set until the next start.
- `start` outside IDLE is ignored. `mode`/`len` changes after start are ignored.
- `in_ready = (state==ACC)`; it is never asserted in IDLE or DONE. Beats offered outside ACC are not consumed.
- `acc*`, `out_mode` and `ovf` are stable while `out_valid && !out_ready`.
- `busy` is high in ACC and DONE.

## Timing
- Reset (async assert; deassertion is synchronous to `CLK` at system level): state IDLE, `acc0..3`=0, `ovf`=0, `out_mode`=0, `out_valid`=0, `in_ready`=0, `busy`=0.
- Reset mid-job aborts the job; nothing is emitted afterwards.
- Start accepted at edge t: `in_ready`=1 from t+1.
- With continuous `in_valid`, `len` beats are consumed in `len` consecutive cycles, one per cycle.
- Last beat accepted at edge t: `out_valid`=1 from t+1, sums include that beat.
- `len==0`: `out_valid` from the edge after start.
- Result accepted at edge t: IDLE at t+1, so the earliest next start is sampled at edge t+1. This gives a minimum of 1 idle cycle between jobs.
- `in_valid` gaps stall the count; no timeout.

## Structure
- Package `simd_mac_pkg` holds:
  - mode constants `MODE_INT8`=2'b00, `MODE_INT4`=2'b01, `MODE_INT2`=2'b10
  - FSM state encoding IDLE/ACC/DONE
  - default `ACC_W`/`LEN_W`
- Sub-module `simd_lane_sat_add`: per-lane adder (ACC_W accumulator + 16-bit zero-extended addend → saturated sum + overflow flag), instantiated 4×.
- Top module: FSM, counter, lane steering mux and registers.

## Test plan
- INT8, `len`=2, `result`=16'hFE01 then 16'h9F60 (255·255, 160·255) → `acc0`=24'h019D61, `acc1..3`=0, `ovf`=0, `out_mode`=00.
- INT4, `len`=1, `result_int4_0`=`result_int4_1`=8'hE1 → `acc0`=`acc1`=225, `acc2`=`acc3`=0.
- INT2, `len`=3, all `result_int2_N`=4'h9 each beat, `in_valid` low on alternating cycles → all four `accN`=27, completes after 3 accepted beats.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → outputs unchanged, `in_ready`=0, `start` ignored; accepted on the 6th cycle → IDLE next cycle.
- Saturation with `ACC_W`=16, INT8, `len`=2, 16'hFE01 twice → `acc0`=16'hFFFF, `ovf`=1. A follow-on job with `len`=0 → `out_valid` the edge after start, all sums 0, `ovf`=0.
- Reset asserted mid-ACC after 1 of 4 beats → all outputs at reset values immediately. A new job afterwards sums correctly from zero.
